// File: rtl/spi_master_if.sv
// Handshake and bus signals of the SPI master: TX FIFO request/data,
// received-word output, SPI pins and the half-period configuration port.
interface spi_master_if #(
    parameter int data_width_c    = 8,
    parameter int reg_din_width_c = 8
);
    // TX FIFO side
    logic                       fifo_req_data;
    logic                       fifo_din_valid;
    logic                       fifo_empty;
    logic [data_width_c-1:0]    fifo_din;

    // Status and received data
    logic                       busy;
    logic [data_width_c-1:0]    dout;
    logic                       dout_valid;

    // SPI pins
    logic                       spi_clk;
    logic                       spi_mosi;
    logic                       spi_miso;
    logic                       spi_ss;

    // Configuration port
    logic [reg_din_width_c-1:0] reg_din;
    logic                       reg_din_val;
    logic                       reg_ack;
    logic                       reg_err;

    // View seen by the SPI master itself
    modport master (
        output fifo_req_data, busy, dout, dout_valid,
               spi_clk, spi_mosi, spi_ss, reg_ack, reg_err,
        input  fifo_din_valid, fifo_empty, fifo_din, spi_miso,
               reg_din, reg_din_val
    );

    // View seen by the surrounding system (FIFO, slave, register host)
    modport slave (
        input  fifo_req_data, busy, dout, dout_valid,
               spi_clk, spi_mosi, spi_ss, reg_ack, reg_err,
        output fifo_din_valid, fifo_empty, fifo_din, spi_miso,
               reg_din, reg_din_val
    );
endinterface

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. Pulls words from a TX FIFO,
// shifts them out while capturing the slave's reply, and keeps slave select
// low across back-to-back words while the FIFO still has data (burst).
// The spi_clk half-period N is programmable while idle.
module spi_master #(
    parameter int data_width_c      = 8,
    parameter int reg_din_width_c   = 8,
    parameter int clk_div_default_c = 2
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);
    localparam int edge_w_c = $clog2(2 * data_width_c);
    localparam logic [edge_w_c-1:0] last_edge_c = edge_w_c'(2 * data_width_c - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        SHIFT,
        DONE
    } state_t;

    state_t                     state;
    logic [reg_din_width_c-1:0] n_cfg;     // programmed half-period
    logic [reg_din_width_c-1:0] n_cur;     // half-period frozen for the word in flight
    logic [reg_din_width_c-1:0] hp_cnt;
    logic [edge_w_c-1:0]        edge_cnt;  // spi_clk toggles done in this word
    logic [data_width_c-1:0]    tx_sr;
    logic [data_width_c-1:0]    rx_sr;

    logic                       fifo_req_q;
    logic                       busy_q;
    logic [data_width_c-1:0]    dout_q;
    logic                       dout_valid_q;
    logic                       sclk_q;
    logic                       mosi_q;
    logic                       ss_q;
    logic                       reg_ack_q;
    logic                       reg_err_q;

    assign bus.fifo_req_data = fifo_req_q;
    assign bus.busy          = busy_q;
    assign bus.dout          = dout_q;
    assign bus.dout_valid    = dout_valid_q;
    assign bus.spi_clk       = sclk_q;
    assign bus.spi_mosi      = mosi_q;
    assign bus.spi_ss        = ss_q;
    assign bus.reg_ack       = reg_ack_q;
    assign bus.reg_err       = reg_err_q;

    // Transfer FSM, clock divider, shift registers and config port in one registered block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            n_cfg        <= reg_din_width_c'(clk_div_default_c);
            n_cur        <= reg_din_width_c'(clk_div_default_c);
            hp_cnt       <= '0;
            edge_cnt     <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            fifo_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            ss_q         <= 1'b1;
            reg_ack_q    <= 1'b0;
            reg_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere below, so every branch reads the
            // pre-edge state and the pulse defaults can be overridden later.
            fifo_req_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            reg_ack_q    <= 1'b0;
            reg_err_q    <= 1'b0;

            // A write is only accepted while idle; it lands on the same edge
            // as a FIFO-triggered start, so that transfer already uses it.
            if (bus.reg_din_val) begin
                if (state == IDLE && bus.reg_din != '0) begin
                    n_cfg     <= bus.reg_din;
                    reg_ack_q <= 1'b1;
                end else begin
                    reg_err_q <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (!bus.fifo_empty) begin
                        state      <= REQ;
                        fifo_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end

                REQ: begin
                    state <= WAIT_DATA;
                end

                WAIT_DATA: begin
                    if (bus.fifo_din_valid) begin
                        tx_sr    <= bus.fifo_din;
                        mosi_q   <= bus.fifo_din[data_width_c-1];
                        ss_q     <= 1'b0;
                        hp_cnt   <= '0;
                        edge_cnt <= '0;
                        n_cur    <= n_cfg;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (hp_cnt == n_cur - 1'b1) begin
                        hp_cnt   <= '0;
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (!sclk_q) begin
                            rx_sr <= {rx_sr[data_width_c-2:0], bus.spi_miso};
                        end else begin
                            tx_sr  <= {tx_sr[data_width_c-2:0], 1'b0};
                            mosi_q <= tx_sr[data_width_c-2];
                            if (edge_cnt == last_edge_c) begin
                                dout_q       <= rx_sr;
                                dout_valid_q <= 1'b1;
                                state        <= DONE;
                            end
                        end
                    end else begin
                        hp_cnt <= hp_cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (!bus.fifo_empty) begin
                        fifo_req_q <= 1'b1;
                        state      <= WAIT_DATA;
                    end else begin
                        ss_q   <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected MOSI words and
// expected received words into queues; a monitor reconstructs words from the
// SPI pins and pops/compares on every completed word and dout_valid strobe.
module tb_spi_master;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_if #(.data_width_c(W), .reg_din_width_c(8)) bus();

    spi_master #(
        .data_width_c     (W),
        .reg_din_width_c  (8),
        .clk_div_default_c(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_n    = 2;

    logic [W-1:0] exp_tx_q[$];
    logic [W-1:0] exp_rx_q[$];
    logic [W-1:0] slv_q[$];

    int req_pulses = 0;
    int sclk_rises = 0;
    int ss_rises   = 0;

    // monitor state
    logic         m_prev_sclk = 1'b0;
    logic         m_prev_ss   = 1'b1;
    int           m_hp        = 0;
    int           m_bits      = 0;
    logic [W-1:0] m_word      = '0;
    logic [W-1:0] m_exp;

    // slave model state
    logic         s_prev_sclk = 1'b0;
    logic         s_prev_ss   = 1'b1;
    int           s_bit       = 0;
    logic [W-1:0] s_word      = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: request/strobe counting, half-period timing, MOSI word rebuild, dout scoreboard
    initial begin : monitor
        forever begin
            tick();
            if (rst) begin
                m_prev_sclk = 1'b0;
                m_prev_ss   = 1'b1;
                m_hp        = 0;
                m_bits      = 0;
            end else begin
                if (bus.fifo_req_data) req_pulses++;
                if (bus.dout_valid) begin
                    if (exp_rx_q.size() == 0) begin
                        check("unexpected_dout_valid", 1, 0);
                    end else begin
                        m_exp = exp_rx_q.pop_front();
                        check("dout", 32'(bus.dout), 32'(m_exp));
                    end
                end
                m_hp++;
                if (bus.spi_clk != m_prev_sclk) begin
                    if (!(bus.spi_clk && m_bits == 0)) check("half_period", m_hp, exp_n);
                    m_hp = 0;
                    if (bus.spi_clk) begin
                        sclk_rises++;
                        m_word = {m_word[W-2:0], bus.spi_mosi};
                        m_bits++;
                        if (m_bits == W) begin
                            m_bits = 0;
                            if (exp_tx_q.size() == 0) begin
                                check("unexpected_mosi_word", 1, 0);
                            end else begin
                                m_exp = exp_tx_q.pop_front();
                                check("mosi_word", 32'(m_word), 32'(m_exp));
                            end
                        end
                    end
                end
                if (bus.spi_ss && !m_prev_ss) begin
                    ss_rises++;
                    m_bits = 0;
                end
                m_prev_sclk = bus.spi_clk;
                m_prev_ss   = bus.spi_ss;
            end
        end
    end

    // Mode-0 slave: presents next MISO bit on select fall and after each spi_clk fall
    initial begin : slave
        bus.spi_miso = 1'b0;
        forever begin
            tick();
            if (rst || (bus.spi_ss && !s_prev_ss)) begin
                s_bit = 0;
            end else if (!bus.spi_ss && s_prev_ss) begin
                s_bit  = 0;
                s_word = (slv_q.size() > 0) ? slv_q.pop_front() : '0;
            end else if (!bus.spi_ss && s_prev_sclk && !bus.spi_clk) begin
                s_bit++;
                if (s_bit == W) begin
                    s_bit = 0;
                    if (slv_q.size() > 0) s_word = slv_q.pop_front();
                end
            end
            bus.spi_miso = s_word[W-1-s_bit];
            s_prev_ss    = bus.spi_ss;
            s_prev_sclk  = bus.spi_clk;
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (bus.fifo_req_data) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("req_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check({tag, "_busy_timeout"}, 0, 1);
    endtask

    task automatic cfg(input logic [7:0] v, input bit exp_ack, input string tag);
        bus.reg_din     = v;
        bus.reg_din_val = 1'b1;
        tick();
        bus.reg_din_val = 1'b0;
        check({tag, "_ack"}, 32'(bus.reg_ack), 32'(exp_ack));
        check({tag, "_err"}, 32'(bus.reg_err), 32'(!exp_ack));
        if (exp_ack) exp_n = int'(v);
        tick();
        check({tag, "_pulse_end"}, 32'({bus.reg_ack, bus.reg_err}), 0);
    endtask

    // One transfer of nw words (1 or 2) from the bench FIFO; delay = cycles data lags the request
    task automatic xfer(input int nw, input logic [7:0] tx0, input logic [7:0] rx0,
                        input logic [7:0] tx1, input logic [7:0] rx1,
                        input int delay, input string tag);
        int req0  = req_pulses;
        int rise0 = sclk_rises;
        int ssr0  = ss_rises;
        int low   = 0;
        bit ok;
        bit idle;
        exp_tx_q.push_back(tx0);
        exp_rx_q.push_back(rx0);
        slv_q.push_back(rx0);
        if (nw == 2) begin
            exp_tx_q.push_back(tx1);
            exp_rx_q.push_back(rx1);
            slv_q.push_back(rx1);
        end
        bus.fifo_empty = 1'b0;
        for (int w = 0; w < nw; w++) begin
            wait_req(ok);
            if (!ok) begin
                bus.fifo_empty = 1'b1;
                return;
            end
            if (w == nw - 1) bus.fifo_empty = 1'b1;
            tick();
            idle = 1'b1;
            for (int d = 0; d < delay; d++) begin
                if (bus.spi_ss !== 1'b1 || bus.spi_clk !== 1'b0) idle = 1'b0;
                tick();
            end
            if (delay > 0) check({tag, "_idle_before_capture"}, 32'(idle), 1);
            bus.fifo_din       = (w == 0) ? tx0 : tx1;
            bus.fifo_din_valid = 1'b1;
            tick();
            bus.fifo_din_valid = 1'b0;
            bus.fifo_din       = '0;
        end
        if (nw == 1) begin
            while (bus.spi_ss == 1'b0 && low < 5000) begin
                low++;
                tick();
            end
            check({tag, "_ss_low_cycles"}, low, 2 * exp_n * W + 1);
        end
        wait_idle(tag);
        tick();
        tick();
        check({tag, "_req_pulses"}, req_pulses - req0, nw);
        check({tag, "_sclk_pulses"}, sclk_rises - rise0, W * nw);
        check({tag, "_ss_rises"}, ss_rises - ssr0, 1);
        check({tag, "_ss_idle"}, 32'(bus.spi_ss), 1);
        check({tag, "_busy_idle"}, 32'(bus.busy), 0);
        check({tag, "_rx_drained"}, exp_rx_q.size(), 0);
        check({tag, "_tx_drained"}, exp_tx_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit ok;
        bus.fifo_empty     = 1'b1;
        bus.fifo_din_valid = 1'b0;
        bus.fifo_din       = '0;
        bus.reg_din        = '0;
        bus.reg_din_val    = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_ss", 32'(bus.spi_ss), 1);
        check("rst_sclk", 32'(bus.spi_clk), 0);
        check("rst_mosi", 32'(bus.spi_mosi), 0);
        check("rst_req", 32'(bus.fifo_req_data), 0);
        check("rst_dout_valid", 32'(bus.dout_valid), 0);
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ack_err", 32'({bus.reg_ack, bus.reg_err}), 0);
        rst = 1'b0;
        tick();

        // Single word at default N=2
        xfer(1, 8'hA5, 8'h3C, 8'h00, 8'h00, 0, "single");
        check("single_dout_hold", 32'(bus.dout), 32'h3C);

        // Burst of two words
        xfer(2, 8'h01, 8'h81, 8'hFF, 8'h7E, 0, "burst");

        // Config accepted, rejected zero, rejected while shifting
        cfg(8'd4, 1'b1, "cfg4");
        cfg(8'd0, 1'b0, "cfg0");
        fork
            xfer(1, 8'h5A, 8'hC3, 8'h00, 8'h00, 0, "n4");
            begin
                for (int i = 0; i < 4000 && bus.spi_ss; i++) tick();
                repeat (5) tick();
                cfg(8'd3, 1'b0, "cfg_busy");
            end
        join

        // Config and FIFO non-empty in the same idle cycle: new N applies
        fork
            cfg(8'd1, 1'b1, "cfg1_same_cycle");
            xfer(1, 8'h96, 8'h69, 8'h00, 8'h00, 0, "n1");
        join

        // Reset in the 10th SHIFT cycle
        cfg(8'd2, 1'b1, "cfg2");
        slv_q.push_back(8'hE7);
        bus.fifo_empty = 1'b0;
        wait_req(ok);
        bus.fifo_empty = 1'b1;
        tick();
        bus.fifo_din       = 8'h3C;
        bus.fifo_din_valid = 1'b1;
        tick();
        bus.fifo_din_valid = 1'b0;
        check("abort_ss_low", 32'(bus.spi_ss), 0);
        repeat (9) tick();
        rst   = 1'b1;
        exp_n = 2;
        #1;
        check("abort_ss", 32'(bus.spi_ss), 1);
        check("abort_sclk", 32'(bus.spi_clk), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_dout_valid", 32'(bus.dout_valid), 0);
        check("abort_dout", 32'(bus.dout), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (40) tick();
        slv_q.delete();

        // Next word after reset, data arriving 7 cycles after the request
        xfer(1, 8'hC3, 8'h5A, 8'h00, 8'h00, 7, "delayed");

        repeat (5) tick();
        check("final_rx_queue", exp_rx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
